// File: rtl/im2col_addr_gen.sv
// im2col read-address walker: emits one tensor-buffer address per im2col element,
// column by column, tagged with packer lane index and lane/column boundaries.
module im2col_addr_gen #(
    parameter int unsigned TENSOR_W   = 8,
    parameter int unsigned KERNEL_W   = 4,
    parameter int unsigned CHANNELS_W = 8,
    parameter int unsigned STRIDE_W   = 4,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned S2P        = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      enable,
    input  logic [TENSOR_W-1:0]       tensor_size,
    input  logic [KERNEL_W-1:0]       kernel_size,
    input  logic [CHANNELS_W-1:0]     channels,
    input  logic [STRIDE_W-1:0]       stride,
    input  logic [TENSOR_W-1:0]       ofs,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [ADDR_W-1:0]         o_addr,
    output logic [$clog2(S2P)-1:0]    o_lane,
    output logic                      o_lane_last,
    output logic                      o_col_last,
    output logic                      o_done,
    output logic                      o_busy
);

    localparam int unsigned LANE_W = $clog2(S2P);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   tt;
    logic [ADDR_W-1:0]   st;
    logic [KERNEL_W-1:0] kx, ky;
    logic [CHANNELS_W-1:0] c;
    logic [TENSOR_W-1:0] ox, oy;
    logic [ADDR_W-1:0]   win_base, row_base, row_off, ch_off;

    logic [KERNEL_W-1:0]   km1;
    logic [CHANNELS_W-1:0] cm1;
    logic                  degenerate;
    logic                  kx_wrap, ky_wrap, c_wrap, ox_wrap, oy_wrap;
    logic                  col_last_cur, last_beat;
    logic [KERNEL_W-1:0]   nxt_kx, nxt_ky;
    logic [CHANNELS_W-1:0] nxt_c;
    logic [TENSOR_W-1:0]   nxt_ox, nxt_oy;
    logic [ADDR_W-1:0]     nxt_win_base, nxt_row_base, nxt_row_off, nxt_ch_off;
    logic [ADDR_W-1:0]     nxt_addr;
    logic [LANE_W-1:0]     nxt_lane;
    logic                  nxt_col_last, nxt_lane_last;
    logic                  first_col_last;

    assign km1        = kernel_size - KERNEL_W'(1);
    assign cm1        = channels - CHANNELS_W'(1);
    assign degenerate = (kernel_size == '0) || (channels == '0);
    assign first_col_last = (kernel_size == KERNEL_W'(1)) && (channels == CHANNELS_W'(1));

    // Next-beat counters and offsets: nested odometer, additive updates only.
    always_comb begin
        kx_wrap = (kx == km1);
        ky_wrap = (ky == km1);
        c_wrap  = (c == cm1);
        ox_wrap = (ox == ofs);
        oy_wrap = (oy == ofs);
        col_last_cur = kx_wrap && ky_wrap && c_wrap;
        last_beat    = col_last_cur && ox_wrap && oy_wrap;

        nxt_kx       = kx;
        nxt_ky       = ky;
        nxt_c        = c;
        nxt_ox       = ox;
        nxt_oy       = oy;
        nxt_win_base = win_base;
        nxt_row_base = row_base;
        nxt_row_off  = row_off;
        nxt_ch_off   = ch_off;

        if (!kx_wrap) begin
            nxt_kx = kx + KERNEL_W'(1);
        end else begin
            nxt_kx = '0;
            if (!ky_wrap) begin
                nxt_ky      = ky + KERNEL_W'(1);
                nxt_row_off = row_off + ADDR_W'(tensor_size);
            end else begin
                nxt_ky      = '0;
                nxt_row_off = '0;
                if (!c_wrap) begin
                    nxt_c      = c + CHANNELS_W'(1);
                    nxt_ch_off = ch_off + tt;
                end else begin
                    nxt_c      = '0;
                    nxt_ch_off = '0;
                    if (!ox_wrap) begin
                        nxt_ox       = ox + TENSOR_W'(1);
                        nxt_win_base = win_base + ADDR_W'(stride);
                    end else begin
                        nxt_ox       = '0;
                        nxt_oy       = oy + TENSOR_W'(1);
                        nxt_row_base = row_base + st;
                        nxt_win_base = row_base + st;
                    end
                end
            end
        end

        nxt_addr      = nxt_ch_off + nxt_win_base + nxt_row_off + ADDR_W'(nxt_kx);
        nxt_lane      = (col_last_cur || (o_lane == LANE_W'(S2P - 1))) ? '0 : o_lane + LANE_W'(1);
        nxt_col_last  = (nxt_kx == km1) && (nxt_ky == km1) && (nxt_c == cm1);
        nxt_lane_last = (nxt_lane == LANE_W'(S2P - 1)) || nxt_col_last;
    end

    // Control FSM, counters and registered stream outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            tt          <= '0;
            st          <= '0;
            kx          <= '0;
            ky          <= '0;
            c           <= '0;
            ox          <= '0;
            oy          <= '0;
            win_base    <= '0;
            row_base    <= '0;
            row_off     <= '0;
            ch_off      <= '0;
            o_valid     <= 1'b0;
            o_addr      <= '0;
            o_lane      <= '0;
            o_lane_last <= 1'b0;
            o_col_last  <= 1'b0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_valid <= 1'b0;
                    if (enable) begin
                        state  <= INIT;
                        o_busy <= 1'b1;
                    end
                end
                INIT: begin
                    if (!enable) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        tt       <= ADDR_W'(tensor_size) * ADDR_W'(tensor_size);
                        st       <= ADDR_W'(stride) * ADDR_W'(tensor_size);
                        kx       <= '0;
                        ky       <= '0;
                        c        <= '0;
                        ox       <= '0;
                        oy       <= '0;
                        win_base <= '0;
                        row_base <= '0;
                        row_off  <= '0;
                        ch_off   <= '0;
                        o_addr   <= '0;
                        o_lane   <= '0;
                        if (degenerate) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            state       <= RUN;
                            o_valid     <= 1'b1;
                            o_col_last  <= first_col_last;
                            o_lane_last <= first_col_last;
                        end
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state       <= IDLE;
                        o_valid     <= 1'b0;
                        o_busy      <= 1'b0;
                        o_lane      <= '0;
                        o_lane_last <= 1'b0;
                        o_col_last  <= 1'b0;
                    end else if (o_valid && i_ready) begin
                        if (last_beat) begin
                            state       <= DONE;
                            o_valid     <= 1'b0;
                            o_done      <= 1'b1;
                            o_busy      <= 1'b0;
                            o_lane      <= '0;
                            o_lane_last <= 1'b0;
                            o_col_last  <= 1'b0;
                        end else begin
                            kx          <= nxt_kx;
                            ky          <= nxt_ky;
                            c           <= nxt_c;
                            ox          <= nxt_ox;
                            oy          <= nxt_oy;
                            win_base    <= nxt_win_base;
                            row_base    <= nxt_row_base;
                            row_off     <= nxt_row_off;
                            ch_off      <= nxt_ch_off;
                            o_addr      <= nxt_addr;
                            o_lane      <= nxt_lane;
                            o_lane_last <= nxt_lane_last;
                            o_col_last  <= nxt_col_last;
                        end
                    end
                end
                DONE: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    if (!enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
